// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the async-FIFO read-side packer.
package fifo_pkg;

  typedef enum logic {FILL, HOLD} packer_state_t;

  // Width of the lane counter; never narrower than one bit.
  function automatic int packer_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words and packs RATIO of them into one valid/ready beat.
// Optional partial-beat flush and lane mask under FIFO_PACKER_FLUSH_EN.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WSIZE     = 8,
  parameter int RATIO     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic [WSIZE-1:0]       rdata,
  input  logic                   rempty,
  output logic                   rinc,
  output logic [WSIZE*RATIO-1:0] m_data,
  output logic                   m_valid,
`ifdef FIFO_PACKER_FLUSH_EN
  input  logic                   flush,
  output logic [RATIO-1:0]       m_keep,
`endif
  input  logic                   m_ready
);

  localparam int CW = packer_cnt_w(RATIO);

  packer_state_t          state;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          lane;
  logic [RATIO-1:0]       lane_sel;
  logic [WSIZE*RATIO-1:0] data_nxt;
  logic                   accept;
  logic                   last;
  logic                   close;
`ifdef FIFO_PACKER_FLUSH_EN
  logic [RATIO-1:0]       keep_nxt;
  logic                   flush_go;
`endif

  // Pop strobe; in HOLD a pop is allowed only on the acceptance cycle.
  always_comb begin
    rinc = !rrst && !rempty && ((state == FILL) || m_ready);
  end

  always_comb begin
    accept   = (state == HOLD) && m_ready;
    lane     = (LSB_FIRST != 0) ? cnt : (CW'(RATIO - 1) - cnt);
    lane_sel = '0;
    if (rinc) lane_sel[lane] = 1'b1;
    data_nxt = m_data;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_sel[i]) data_nxt[i*WSIZE +: WSIZE] = rdata;
    end
    last  = (state == FILL) && rinc && (cnt == CW'(RATIO - 1));
    close = last;
`ifdef FIFO_PACKER_FLUSH_EN
    keep_nxt = (accept ? '0 : m_keep) | lane_sel;
    flush_go = (state == FILL) && flush && ((cnt != '0) || rinc);
    // A flushed partial beat zeroes the lanes it never wrote.
    if (flush_go) begin
      for (int i = 0; i < RATIO; i++) begin
        if (!keep_nxt[i]) data_nxt[i*WSIZE +: WSIZE] = '0;
      end
    end
    close = last || flush_go;
`endif
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state   <= FILL;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
`ifdef FIFO_PACKER_FLUSH_EN
      m_keep  <= '0;
`endif
    end else begin
      m_data <= data_nxt;
`ifdef FIFO_PACKER_FLUSH_EN
      m_keep <= keep_nxt;
`endif
      case (state)
        FILL: begin
          if (close) begin
            state   <= HOLD;
            m_valid <= 1'b1;
            cnt     <= '0;
          end else if (rinc) begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (m_ready) begin
            state   <= FILL;
            m_valid <= 1'b0;
            cnt     <= rinc ? CW'(1) : '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: LSB-first and MSB-first instances share one FIFO model.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rrst;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc, rinc_m;
  logic [31:0] m_data, m_data_m;
  logic        m_valid, m_valid_m;
  logic        m_ready;
`ifdef FIFO_PACKER_FLUSH_EN
  logic        flush;
  logic [3:0]  m_keep, m_keep_m;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:63];
  logic [5:0] rp = 6'd0;
  logic [5:0] wp = 6'd0;

  always #5 clk = ~clk;

  assign rempty = (rp == wp);
  assign rdata  = mem[rp];

  always @(posedge clk) begin
    if (rinc) rp <= rp + 6'd1;
  end

  fifo_rd_packer #(.WSIZE(8), .RATIO(4), .LSB_FIRST(1)) dut (
    .rclk(clk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .m_data(m_data), .m_valid(m_valid),
`ifdef FIFO_PACKER_FLUSH_EN
    .flush(flush), .m_keep(m_keep),
`endif
    .m_ready(m_ready)
  );

  fifo_rd_packer #(.WSIZE(8), .RATIO(4), .LSB_FIRST(0)) dut_msb (
    .rclk(clk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc_m),
    .m_data(m_data_m), .m_valid(m_valid_m),
`ifdef FIFO_PACKER_FLUSH_EN
    .flush(flush), .m_keep(m_keep_m),
`endif
    .m_ready(m_ready)
  );

  task automatic push(input logic [7:0] v);
    mem[wp] = v;
    wp = wp + 6'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m_ready = 1'b1;
    rrst    = 1'b1;
    push(8'h5A);
    #1;
    checks++;
    if (rinc !== 1'b0) begin
      failures++;
      $display("FAIL reset_rinc: got %b want 0", rinc);
    end
    step();
    step();
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b data=%h want 0/00000000", m_valid, m_data);
    end
    checks++;
    if (rinc !== 1'b0 || rp !== 6'd0) begin
      failures++;
      $display("FAIL reset_no_pop: got rinc=%b rp=%0d want 0/0", rinc, rp);
    end
    wp = rp;
    rrst = 1'b0;
    step();
  endtask

  task automatic test_pack_basic();
    int pops = 0;
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (rinc === 1'b1 && rinc_m === 1'b1) pops++;
      step();
    end
    checks++;
    if (pops != 4) begin
      failures++;
      $display("FAIL basic_pops: got %0d want 4", pops);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h44332211) begin
      failures++;
      $display("FAIL basic_lsb: got valid=%b data=%h want 1/44332211", m_valid, m_data);
    end
    checks++;
    if (m_valid_m !== 1'b1 || m_data_m !== 32'h11223344) begin
      failures++;
      $display("FAIL basic_msb: got valid=%b data=%h want 1/11223344", m_valid_m, m_data_m);
    end
    checks++;
    if (rinc !== 1'b0) begin
      failures++;
      $display("FAIL basic_empty_rinc: got %b want 0", rinc);
    end
    step();
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_one_cycle: got valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    m_ready = 1'b0;
    for (int k = 1; k <= 8; k++) push(8'(k));
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h04030201) begin
      failures++;
      $display("FAIL stall_first: got valid=%b data=%h want 1/04030201", m_valid, m_data);
    end
    for (int k = 0; k < 5; k++) begin
      if (rinc !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h04030201) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
    end
    m_ready = 1'b1;
    #1;
    checks++;
    if (rinc !== 1'b1) begin
      failures++;
      $display("FAIL stall_accept_pop: got rinc=%b want 1", rinc);
    end
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h08070605) begin
      failures++;
      $display("FAIL stall_second: got valid=%b data=%h want 1/08070605", m_valid, m_data);
    end
    step();
    checks++;
    if (m_valid !== 1'b0 || rp !== wp) begin
      failures++;
      $display("FAIL stall_drain: got valid=%b rp=%0d wp=%0d want 0 rp==wp", m_valid, rp, wp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_beats [3];
    int bad_rinc = 0;
    exp_beats[0] = 32'h13121110;
    exp_beats[1] = 32'h17161514;
    exp_beats[2] = 32'h1B1A1918;
    m_ready = 1'b1;
    for (int k = 0; k < 12; k++) push(8'(8'h10 + k));
    #1;
    for (int i = 1; i <= 12; i++) begin
      if (rinc !== 1'b1) bad_rinc++;
      step();
      checks++;
      if ((i % 4) == 0) begin
        if (m_valid !== 1'b1 || m_data !== exp_beats[i/4-1]) begin
          failures++;
          $display("FAIL b2b_beat%0d: got valid=%b data=%h want 1/%h", i/4, m_valid,
                   m_data, exp_beats[i/4-1]);
        end
      end else if (m_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_gap_cycle%0d: got valid=%b want 0", i, m_valid);
      end
    end
    checks++;
    if (bad_rinc != 0) begin
      failures++;
      $display("FAIL b2b_rinc: got %0d idle cycles want 0", bad_rinc);
    end
    step();
  endtask

  task automatic test_reset_mid_beat();
    int bad = 0;
    m_ready = 1'b1;
    push(8'hA1); push(8'hA2);
    step(); step();
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    rrst = 1'b1;
    #1;
    checks++;
    if (rinc !== 1'b0) begin
      failures++;
      $display("FAIL midrst_rinc: got %b want 0", rinc);
    end
    step();
    rrst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m_valid !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_valid_low: got %0d cycles valid want 0", bad);
    end
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hB4B3B2B1) begin
      failures++;
      $display("FAIL midrst_beat: got valid=%b data=%h want 1/B4B3B2B1", m_valid, m_data);
    end
    step();
  endtask

`ifdef FIFO_PACKER_FLUSH_EN
  task automatic test_flush();
    m_ready = 1'b1;
    flush   = 1'b0;
    push(8'hAA); push(8'hBB); push(8'hCC);
    step(); step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h00CCBBAA || m_keep !== 4'b0111) begin
      failures++;
      $display("FAIL flush_lsb: got valid=%b data=%h keep=%b want 1/00CCBBAA/0111",
               m_valid, m_data, m_keep);
    end
    checks++;
    if (m_data_m !== 32'hAABBCC00 || m_keep_m !== 4'b1110) begin
      failures++;
      $display("FAIL flush_msb: got data=%h keep=%b want AABBCC00/1110", m_data_m, m_keep_m);
    end
    step();
    checks++;
    if (m_valid !== 1'b0 || m_keep !== 4'b0000) begin
      failures++;
      $display("FAIL flush_accept: got valid=%b keep=%b want 0/0000", m_valid, m_keep);
    end
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty_ignored: got valid=%b want 0", m_valid);
    end
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h04030201 || m_keep !== 4'b1111) begin
      failures++;
      $display("FAIL flush_full_keep: got valid=%b data=%h keep=%b want 1/04030201/1111",
               m_valid, m_data, m_keep);
    end
    step();
  endtask
`endif

  initial begin
    rrst    = 1'b1;
    m_ready = 1'b0;
`ifdef FIFO_PACKER_FLUSH_EN
    flush   = 1'b0;
`endif
    test_reset();
    test_pack_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid_beat();
`ifdef FIFO_PACKER_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
